riscv_ctrl: RTL and testbench

Multi-cycle sequencer for the single-issue RV32I datapath: decoder, ALU and register file. It fetches each instruction from instruction memory over a request/ready handshake and holds it in an instruction register. It then steps the datapath through DECODE, EXEC and WB, pulsing the register-file write enable exactly once per retired instruction. It owns the PC and halts the core permanently on an instruction the decoder flags invalid.

---
 rtl/riscv_ctrl_pkg.sv | 25 ++
 rtl/riscv_pc.sv | 28 ++
 rtl/riscv_ctrl.sv | 103 ++++++++++
 tb/tb_riscv_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle core: sequencer states, datapath
// select encodings, PC step and the canonical NOP.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_t;

  typedef enum logic [3:0] {
    FUN_ADD, FUN_SUB, FUN_AND, FUN_OR, FUN_XOR,
    FUN_SLL, FUN_SRL, FUN_SRA, FUN_SLT, FUN_SLTU
  } exec_fun_t;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU} op2_sel_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/riscv_pc.sv
// Program counter register: synchronous active-low reset to RESET_PC and a
// load-enabled +PC_STEP advance that wraps modulo 2^32.
module riscv_pc
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  assign pc_next = pc_reg + PC_STEP;
  assign pc      = pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (load_en) begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/riscv_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/WB with a halting state for invalid
// instructions. Optional retired-instruction counter under RISCV_CTRL_INSTRET_EN.
module riscv_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        invalid_i,
  output logic        write_en,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] instret
);

  ctrl_state_t state_reg, state_next;
  logic [31:0] inst_reg;
  logic        inst_load;

  riscv_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (write_en),
    .pc      (pc)
  );

  assign imem_addr = pc;
  assign inst      = inst_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      inst_reg  <= NOP_INST;
    end else begin
      state_reg <= state_next;
      if (inst_load) begin
        inst_reg <= imem_rdata;
      end
    end
  end

  // All outputs decode from the current state, so a reset edge ending EXEC
  // never lets a WB write escape.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    write_en   = 1'b0;
    halted     = 1'b0;
    inst_load  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_load  = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = invalid_i ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_WB;
      end
      ST_WB: begin
        write_en   = 1'b1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef RISCV_CTRL_INSTRET_EN
  logic [31:0] instret_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_reg <= 32'h0;
    end else if (write_en) begin
      instret_reg <= instret_reg + 32'd1;
    end
  end

  assign instret = instret_reg;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_ctrl.sv
// Directed bench for riscv_ctrl: two instances share stimulus, one at the
// default RESET_PC and one at 32'hFFFF_FFFC to exercise PC wrap.
module tb_riscv_ctrl;

`ifdef RISCV_CTRL_INSTRET_EN
  localparam bit INSTRET_EN = 1'b1;
`else
  localparam bit INSTRET_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        invalid_i;

  logic        imem_req, write_en, halted;
  logic [31:0] imem_addr, inst, pc, instret;
  logic        w_imem_req, w_write_en, w_halted;
  logic [31:0] w_imem_addr, w_inst, w_pc, w_instret;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .invalid_i(invalid_i), .write_en(write_en),
    .pc(pc), .halted(halted), .instret(instret)
  );

  riscv_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(w_inst), .invalid_i(invalid_i), .write_en(w_write_en),
    .pc(w_pc), .halted(w_halted), .instret(w_instret)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] exp_ret(input int n);
    return INSTRET_EN ? 32'(n) : 32'h0;
  endfunction

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0;
    imem_rdata = 32'h0; invalid_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_we", {31'b0, write_en}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    // Two back-to-back instructions with imem_ready high
    rst_n = 1'b1; run = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    tick();  // cycle 1: FETCH
    check("i1_req", {31'b0, imem_req}, 32'h1);
    check("i1_addr", imem_addr, 32'h0);
    check("i1_wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    tick();  // cycle 2: DECODE
    check("i1_inst", inst, 32'h0050_0093);
    check("i1_req_dec", {31'b0, imem_req}, 32'h0);
    tick();  // cycle 3: EXEC
    check("i1_we_exec", {31'b0, write_en}, 32'h0);
    tick();  // cycle 4: WB
    check("i1_we_wb", {31'b0, write_en}, 32'h1);
    check("i1_pc_wb", pc, 32'h0);
    imem_rdata = 32'h0030_8113;
    tick();  // cycle 5: FETCH
    check("i2_we_off", {31'b0, write_en}, 32'h0);
    check("i2_addr", imem_addr, 32'h4);
    check("i1_instret", instret, exp_ret(1));
    check("wrap_pc0", w_pc, 32'h0);
    tick();  // DECODE
    check("i2_inst", inst, 32'h0030_8113);
    tick();  // EXEC
    tick();  // cycle 8: WB
    check("i2_we_wb", {31'b0, write_en}, 32'h1);
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    tick();  // FETCH wait 1
    check("i2_pc", pc, 32'h8);
    check("i2_instret", instret, exp_ret(2));
    check("wrap_pc4", w_pc, 32'h4);

    // imem_ready low for three FETCH cycles; request must hold steady
    check("w1_req", {31'b0, imem_req}, 32'h1);
    check("w1_addr", imem_addr, 32'h8);
    tick();
    check("w2_req", {31'b0, imem_req}, 32'h1);
    check("w2_addr", imem_addr, 32'h8);
    check("w2_inst", inst, 32'h0030_8113);
    tick();
    check("w3_req", {31'b0, imem_req}, 32'h1);
    check("w3_addr", imem_addr, 32'h8);
    tick();
    check("w4_req", {31'b0, imem_req}, 32'h1);
    check("w4_addr", imem_addr, 32'h8);
    imem_ready = 1'b1; imem_rdata = 32'hFFF0_0193;
    tick();  // DECODE
    check("i3_inst", inst, 32'hFFF0_0193);
    imem_rdata = 32'h0;
    tick();  // EXEC; drop run mid-instruction
    run = 1'b0;
    tick();  // WB (7th cycle of this instruction)
    check("i3_we_wb", {31'b0, write_en}, 32'h1);
    tick();  // IDLE
    check("i3_idle_req", {31'b0, imem_req}, 32'h0);
    check("i3_pc", pc, 32'hC);
    check("i3_instret", instret, exp_ret(3));
    tick();
    check("idle_req_hold", {31'b0, imem_req}, 32'h0);
    check("idle_we_hold", {31'b0, write_en}, 32'h0);

    // Invalid instruction halts permanently
    run = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();  // FETCH
    check("inv_req", {31'b0, imem_req}, 32'h1);
    check("inv_addr", imem_addr, 32'hC);
    tick();  // DECODE
    invalid_i = 1'b1;
    tick();  // HALT
    invalid_i = 1'b0;
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_we", {31'b0, write_en}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_hold", {31'b0, halted}, 32'h1);
      check("halt_req", {31'b0, imem_req}, 32'h0);
      check("halt_we_hold", {31'b0, write_en}, 32'h0);
    end
    check("halt_pc", pc, 32'hC);
    check("halt_instret", instret, exp_ret(3));

    // Reset landing on the edge into WB suppresses the write
    rst_n = 1'b0;
    tick();
    check("rst2_halted", {31'b0, halted}, 32'h0);
    check("rst2_pc", pc, 32'h0);
    rst_n = 1'b1; imem_rdata = 32'h0050_0093;
    tick();  // FETCH
    tick();  // DECODE
    tick();  // EXEC
    rst_n = 1'b0;
    tick();
    check("rstwb_we", {31'b0, write_en}, 32'h0);
    check("rstwb_pc", pc, 32'h0);
    check("rstwb_req", {31'b0, imem_req}, 32'h0);
    check("rstwb_inst", inst, 32'h0000_0013);
    check("rstwb_instret", instret, 32'h0);
    tick();
    check("rstwb_we2", {31'b0, write_en}, 32'h0);

    // Reset mid-FETCH drops the request
    rst_n = 1'b1; imem_ready = 1'b0;
    tick();  // FETCH
    check("rstf_req_on", {31'b0, imem_req}, 32'h1);
    rst_n = 1'b0;
    tick();
    check("rstf_req_off", {31'b0, imem_req}, 32'h0);
    check("rstf_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
